// File: rtl/svm_pkg.sv
// Shared definitions for the SVM cascade stages: FSM state codes and
// address/index width helpers used by the sequencer, kernel and decision blocks.
package svm_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_LOAD     = 3'd1;
   localparam logic [2:0] ST_COMPUTE  = 3'd2;
   localparam logic [2:0] ST_DRAIN    = 3'd3;
   localparam logic [2:0] ST_DECIDE   = 3'd4;
   localparam logic [2:0] ST_WAIT_DEC = 3'd5;

   typedef logic [2:0] state_t;

   // A single-entry range still needs a one-bit address.
   function automatic int pix_aw_f(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int sv_w_f(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/svm_sv_sequencer_if.sv
// Handshake and memory/MAC control bundle of the SVM stage sequencer.
// master = sequencer side, slave = surrounding memories, MAC and decision logic.
interface svm_sv_sequencer_if
   import svm_pkg::*;
#(
   parameter int PIX_AW = pix_aw_f(784),
   parameter int SV_W   = sv_w_f(10)
);
   logic              start;
   logic              pix_valid;
   logic              pix_ready;
   logic              we;
   logic [PIX_AW-1:0] waddr;
   logic              hold;
   logic              re;
   logic [PIX_AW-1:0] raddr;
   logic [SV_W-1:0]   sv_idx;
   logic              mac_clr;
   logic              mac_last;
   logic              kernel_valid;
   logic [SV_W-1:0]   sv_idx_o;
   logic              stall_MEM;
   logic              decision_funct_en;
   logic              dec_done;
   logic              busy;
   logic              done;

   modport master (
      input  start, pix_valid, hold, dec_done,
      output pix_ready, we, waddr, re, raddr, sv_idx, mac_clr, mac_last,
             kernel_valid, sv_idx_o, stall_MEM, decision_funct_en, busy, done
   );

   modport slave (
      output start, pix_valid, hold, dec_done,
      input  pix_ready, we, waddr, re, raddr, sv_idx, mac_clr, mac_last,
             kernel_valid, sv_idx_o, stall_MEM, decision_funct_en, busy, done
   );
endinterface

// File: rtl/svm_delay_line.sv
// Fixed-depth shift register that mirrors the MAC pipeline so result tags
// line up with the MAC output; cleared by the synchronous active-low reset.
module svm_delay_line #(
   parameter int DEPTH = 3,
   parameter int W     = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         logic [W-1:0] stage_q;
         logic [W-1:0] stage_d;

         if (gi == 0) begin : g_head
            always_comb stage_d = din;
         end else begin : g_tail
            always_comb stage_d = g_stage[gi-1].stage_q;
         end

         always_ff @(posedge clk) begin
            if (!rst) stage_q <= '0;
            else      stage_q <= stage_d;
         end
      end
   endgenerate

   assign dout = g_stage[DEPTH-1].stage_q;
endmodule

// File: rtl/svm_sv_sequencer.sv
// Per-test-vector sequencer for one binary SVM stage: loads the pixels, streams every
// (support vector, pixel) beat to the kernel MAC, drains it and fires the decision function.
module svm_sv_sequencer
   import svm_pkg::*;
#(
   parameter int XLEN_PIXEL    = 8,
   parameter int NUM_OF_PIXELS = 784,
   parameter int NUM_OF_SV     = 10,
   parameter int MAC_LATENCY   = 3
) (
   input  logic               clk,
   input  logic               rst,
   svm_sv_sequencer_if.master bus
);
   localparam int PIX_AW = pix_aw_f(NUM_OF_PIXELS);
   localparam int SV_W   = sv_w_f(NUM_OF_SV);
   localparam int DEPTH  = (MAC_LATENCY < 1) ? 1 : MAC_LATENCY;
   localparam int DRN_W  = $clog2(DEPTH + 1);
   localparam logic [PIX_AW-1:0] LAST_PIX = PIX_AW'(NUM_OF_PIXELS - 1);
   localparam logic [SV_W-1:0]   LAST_SV  = SV_W'(NUM_OF_SV - 1);
   localparam logic [DRN_W-1:0]  LAST_DRN = DRN_W'(DEPTH - 1);

   // Pixel width only sizes the external memories; the sequencer carries no pixel data.
   if (XLEN_PIXEL < 1) begin : g_xlen_must_be_positive
   end

   state_t            state_q, state_d;
   logic [PIX_AW-1:0] load_cnt_q, load_cnt_d;
   logic [PIX_AW-1:0] pix_cnt_q, pix_cnt_d;
   logic [SV_W-1:0]   sv_cnt_q, sv_cnt_d;
   logic [DRN_W-1:0]  drain_cnt_q, drain_cnt_d;

   logic              pix_ready_q, pix_ready_d;
   logic              re_q, re_d;
   logic [PIX_AW-1:0] raddr_q, raddr_d;
   logic [SV_W-1:0]   sv_idx_q, sv_idx_d;
   logic              mac_clr_q, mac_clr_d;
   logic              mac_last_q, mac_last_d;
   logic              dfe_q, dfe_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              accept;
   logic              issue;
   logic [SV_W:0]     kv_in, kv_out;

   assign accept = bus.pix_valid & pix_ready_q;

   always_comb begin
      state_d     = state_q;
      load_cnt_d  = load_cnt_q;
      pix_cnt_d   = pix_cnt_q;
      sv_cnt_d    = sv_cnt_q;
      drain_cnt_d = drain_cnt_q;
      issue       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (accept) begin
               if (load_cnt_q == LAST_PIX) begin
                  load_cnt_d = '0;
                  state_d    = ST_COMPUTE;
               end else begin
                  load_cnt_d = load_cnt_q + 1'b1;
               end
            end
         end
         ST_COMPUTE: begin
            // Back-pressure freezes both counters, so a held beat is reissued unchanged.
            if (!bus.hold) begin
               issue = 1'b1;
               if (pix_cnt_q == LAST_PIX) begin
                  pix_cnt_d = '0;
                  if (sv_cnt_q == LAST_SV) begin
                     sv_cnt_d = '0;
                     state_d  = ST_DRAIN;
                  end else begin
                     sv_cnt_d = sv_cnt_q + 1'b1;
                  end
               end else begin
                  pix_cnt_d = pix_cnt_q + 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (drain_cnt_q == LAST_DRN) begin
               drain_cnt_d = '0;
               state_d     = ST_DECIDE;
            end else begin
               drain_cnt_d = drain_cnt_q + 1'b1;
            end
         end
         ST_DECIDE: begin
            state_d = ST_WAIT_DEC;
         end
         ST_WAIT_DEC: begin
            if (bus.dec_done) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      pix_ready_d = (state_d == ST_LOAD);
      re_d        = issue;
      raddr_d     = pix_cnt_q;
      sv_idx_d    = sv_cnt_q;
      mac_clr_d   = issue && (pix_cnt_q == '0);
      mac_last_d  = issue && (pix_cnt_q == LAST_PIX);
      // Pulses one cycle after DECIDE so it lands after the final kernel_valid.
      dfe_d       = (state_q == ST_DECIDE);
      busy_d      = (state_d != ST_IDLE);
      done_d      = (state_q == ST_WAIT_DEC) && bus.dec_done;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         load_cnt_q  <= '0;
         pix_cnt_q   <= '0;
         sv_cnt_q    <= '0;
         drain_cnt_q <= '0;
         pix_ready_q <= 1'b0;
         re_q        <= 1'b0;
         raddr_q     <= '0;
         sv_idx_q    <= '0;
         mac_clr_q   <= 1'b0;
         mac_last_q  <= 1'b0;
         dfe_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         load_cnt_q  <= load_cnt_d;
         pix_cnt_q   <= pix_cnt_d;
         sv_cnt_q    <= sv_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         pix_ready_q <= pix_ready_d;
         re_q        <= re_d;
         raddr_q     <= raddr_d;
         sv_idx_q    <= sv_idx_d;
         mac_clr_q   <= mac_clr_d;
         mac_last_q  <= mac_last_d;
         dfe_q       <= dfe_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Only the last beat's tag is carried, so sv_idx_o reads zero between pulses.
   assign kv_in = {mac_last_q, sv_idx_q & {SV_W{mac_last_q}}};

   svm_delay_line #(
      .DEPTH (DEPTH),
      .W     (SV_W + 1)
   ) u_delay (
      .clk  (clk),
      .rst  (rst),
      .din  (kv_in),
      .dout (kv_out)
   );

   assign bus.pix_ready         = pix_ready_q;
   assign bus.stall_MEM         = pix_ready_q;
   assign bus.we                = accept;
   assign bus.waddr             = load_cnt_q;
   assign bus.re                = re_q;
   assign bus.raddr             = raddr_q;
   assign bus.sv_idx            = sv_idx_q;
   assign bus.mac_clr           = mac_clr_q;
   assign bus.mac_last          = mac_last_q;
   assign bus.kernel_valid      = kv_out[SV_W];
   assign bus.sv_idx_o          = kv_out[SV_W-1:0];
   assign bus.decision_funct_en = dfe_q;
   assign bus.busy              = busy_q;
   assign bus.done              = done_q;
endmodule

// File: tb/tb_svm_sv_sequencer.sv
// Scoreboard bench for svm_sv_sequencer: directed vectors push cycle-stamped expected
// events, a negedge monitor pops and compares every write, beat, kernel_valid, dfe and done.
module tb_svm_sv_sequencer;
   import svm_pkg::*;

   localparam int NP    = 4;
   localparam int NS_A  = 2;
   localparam int LAT_A = 2;
   localparam int NS_B  = 1;
   localparam int LAT_B = 1;
   localparam int K_WE = 0, K_RE = 1, K_KV = 2, K_DF = 3, K_DN = 4;

   typedef struct {
      int cyc;
      int val;
   } exp_t;

   typedef struct packed {
      logic       we;
      logic [1:0] waddr;
      logic       re;
      logic [1:0] raddr;
      logic       sv;
      logic       clr;
      logic       last;
      logic       kv;
      logic       svo;
      logic       dfe;
      logic       done;
      logic       pr;
      logic       stall;
      logic       busy;
   } obs_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_v   [2];
   logic start_v [2];
   logic pv_v    [2];
   logic hold_v  [2];
   logic dd_v    [2];

   int cyc    = 0;
   int checks = 0;
   int errors = 0;
   exp_t eq [10][$];

   always @(posedge clk) cyc <= cyc + 1;

   svm_sv_sequencer_if #(.PIX_AW(2), .SV_W(1)) bus_a ();
   svm_sv_sequencer_if #(.PIX_AW(2), .SV_W(1)) bus_b ();

   assign bus_a.start     = start_v[0];
   assign bus_a.pix_valid = pv_v[0];
   assign bus_a.hold      = hold_v[0];
   assign bus_a.dec_done  = dd_v[0];
   assign bus_b.start     = start_v[1];
   assign bus_b.pix_valid = pv_v[1];
   assign bus_b.hold      = hold_v[1];
   assign bus_b.dec_done  = dd_v[1];

   svm_sv_sequencer #(
      .XLEN_PIXEL(8), .NUM_OF_PIXELS(NP), .NUM_OF_SV(NS_A), .MAC_LATENCY(LAT_A)
   ) dut_a (
      .clk (clk),
      .rst (rst_v[0]),
      .bus (bus_a)
   );

   svm_sv_sequencer #(
      .XLEN_PIXEL(8), .NUM_OF_PIXELS(NP), .NUM_OF_SV(NS_B), .MAC_LATENCY(LAT_B)
   ) dut_b (
      .clk (clk),
      .rst (rst_v[1]),
      .bus (bus_b)
   );

   function automatic obs_t sample(input int d);
      obs_t o;
      o.we    = (d == 0) ? bus_a.we                : bus_b.we;
      o.waddr = (d == 0) ? bus_a.waddr             : bus_b.waddr;
      o.re    = (d == 0) ? bus_a.re                : bus_b.re;
      o.raddr = (d == 0) ? bus_a.raddr             : bus_b.raddr;
      o.sv    = (d == 0) ? bus_a.sv_idx            : bus_b.sv_idx;
      o.clr   = (d == 0) ? bus_a.mac_clr           : bus_b.mac_clr;
      o.last  = (d == 0) ? bus_a.mac_last          : bus_b.mac_last;
      o.kv    = (d == 0) ? bus_a.kernel_valid      : bus_b.kernel_valid;
      o.svo   = (d == 0) ? bus_a.sv_idx_o          : bus_b.sv_idx_o;
      o.dfe   = (d == 0) ? bus_a.decision_funct_en : bus_b.decision_funct_en;
      o.done  = (d == 0) ? bus_a.done              : bus_b.done;
      o.pr    = (d == 0) ? bus_a.pix_ready         : bus_b.pix_ready;
      o.stall = (d == 0) ? bus_a.stall_MEM         : bus_b.stall_MEM;
      o.busy  = (d == 0) ? bus_a.busy              : bus_b.busy;
      return o;
   endfunction

   function automatic string kname(input int k);
      case (k)
         K_WE:    return "we";
         K_RE:    return "beat";
         K_KV:    return "kernel_valid";
         K_DF:    return "decision_funct_en";
         default: return "done";
      endcase
   endfunction

   task automatic push(input int d, input int k, input int c, input int v);
      exp_t e;
      e.cyc = c;
      e.val = v;
      eq[d*5+k].push_back(e);
   endtask

   task automatic check_evt(input int d, input int k, input int v);
      exp_t e;
      checks++;
      if (eq[d*5+k].size() == 0) begin
         errors++;
         $display("FAIL %s dut%0d: unexpected event at cycle %0d val %0d, none expected",
                  kname(k), d, cyc, v);
      end else begin
         e = eq[d*5+k].pop_front();
         if (e.cyc != cyc || e.val != v) begin
            errors++;
            $display("FAIL %s dut%0d: got cycle %0d val %0d, expected cycle %0d val %0d",
                     kname(k), d, cyc, v, e.cyc, e.val);
         end
      end
   endtask

   // Monitor: every DUT output event is matched against the scoreboard.
   always @(negedge clk) begin
      obs_t o;
      for (int d = 0; d < 2; d++) begin
         o = sample(d);
         if (o.we === 1'b1)   check_evt(d, K_WE, int'(o.waddr));
         if (o.re === 1'b1)   check_evt(d, K_RE, int'(o.raddr) + 4*int'(o.sv) + 8*int'(o.clr) + 16*int'(o.last));
         if (o.kv === 1'b1)   check_evt(d, K_KV, int'(o.svo));
         if (o.dfe === 1'b1)  check_evt(d, K_DF, 0);
         if (o.done === 1'b1) check_evt(d, K_DN, 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input int d, input string what);
      obs_t o;
      o = sample(d);
      checks++;
      if (o !== '0) begin
         errors++;
         $display("FAIL %s dut%0d: outputs 0x%0h, expected all zero", what, d, o);
      end
   endtask

   function automatic int beat_vis(input int ta, input int b, input int hb, input int hl);
      return ta + 1 + b + ((hb >= 0 && b >= hb) ? hl : 0);
   endfunction

   // One test vector. hb/hl: hold window before beat hb; rb: reset right after beat rb;
   // spur: extra start pulses in LOAD and WAIT_DEC; dd: cycles from dfe to dec_done.
   task automatic run_vec(input int d, input bit gap, input int hb, input int hl,
                          input int rb, input bit spur, input int dd);
      int ns, lat, ta, k, step, nb, vis, r_edge, t_last, e_dn, e_end, nx;
      obs_t o;
      ns  = (d == 0) ? NS_A  : NS_B;
      lat = (d == 0) ? LAT_A : LAT_B;
      start_v[d] = 1'b1;
      tick();
      start_v[d] = 1'b0;
      o = sample(d);
      checks++;
      if (!(o.pr === 1'b1 && o.stall === 1'b1 && o.busy === 1'b1)) begin
         errors++;
         $display("FAIL load_entry dut%0d: pix_ready %b stall_MEM %b busy %b, expected 1 1 1",
                  d, o.pr, o.stall, o.busy);
      end
      k = 0;
      step = 0;
      while (k < NP) begin
         pv_v[d]    = gap ? ((step % 2) == 0) : 1'b1;
         start_v[d] = spur && (step == 2);
         if (pv_v[d]) push(d, K_WE, cyc, k);
         tick();
         if (pv_v[d]) k++;
         step++;
      end
      pv_v[d]    = 1'b0;
      start_v[d] = 1'b0;
      ta = cyc;
      nb = NP * ns;
      r_edge = (rb >= 0) ? beat_vis(ta, rb, hb, hl) + 1 : -1;
      for (int b = 0; b < nb; b++) begin
         if (rb >= 0 && b > rb) break;
         vis = beat_vis(ta, b, hb, hl);
         push(d, K_RE, vis, (b % NP) + 4*(b / NP) + 8*((b % NP) == 0) + 16*((b % NP) == NP-1));
         if ((b % NP) == NP-1 && (rb < 0 || vis + lat < r_edge)) push(d, K_KV, vis + lat, b / NP);
      end
      t_last = beat_vis(ta, nb-1, hb, hl);
      e_dn   = t_last + lat + 2 + dd;
      if (rb < 0) begin
         push(d, K_DF, t_last + lat + 1, 0);
         push(d, K_DN, e_dn, 0);
      end
      e_end = (rb >= 0) ? r_edge + 2 : e_dn + 2;
      while (cyc < e_end) begin
         nx = cyc + 1;
         hold_v[d]  = (hb >= 0) && (nx >= ta + 1 + hb) && (nx < ta + 1 + hb + hl);
         rst_v[d]   = !((rb >= 0) && (nx == r_edge));
         dd_v[d]    = (rb < 0) && (nx == e_dn);
         start_v[d] = spur && (rb < 0) && (dd >= 1) && (nx == t_last + lat + 2);
         tick();
         if (rb >= 0 && cyc == r_edge) check_zero(d, "reset_mid_compute");
      end
      hold_v[d]  = 1'b0;
      rst_v[d]   = 1'b1;
      dd_v[d]    = 1'b0;
      start_v[d] = 1'b0;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst_v[d]   = 1'b0;
         start_v[d] = 1'b0;
         pv_v[d]    = 1'b0;
         hold_v[d]  = 1'b0;
         dd_v[d]    = 1'b0;
      end
      repeat (3) tick();
      check_zero(0, "reset_state");
      check_zero(1, "reset_state");
      rst_v[0] = 1'b1;
      rst_v[1] = 1'b1;
      tick();

      run_vec(0, 1'b0, -1, 0, -1, 1'b0, 2);   // nominal
      run_vec(0, 1'b1, -1, 0, -1, 1'b0, 1);   // gapped load
      run_vec(0, 1'b0,  3, 3, -1, 1'b0, 1);   // hold across the pixel wrap
      run_vec(0, 1'b0, -1, 0,  4, 1'b0, 0);   // reset while beat 5 is out
      run_vec(0, 1'b0, -1, 0, -1, 1'b0, 1);   // full vector after the abort
      run_vec(0, 1'b0, -1, 0, -1, 1'b1, 3);   // spurious starts
      run_vec(1, 1'b0, -1, 0, -1, 1'b0, 0);   // latency 1, one SV, same-cycle dec_done

      repeat (6) tick();
      for (int qi = 0; qi < 10; qi++) begin
         checks++;
         if (eq[qi].size() != 0) begin
            errors++;
            $display("FAIL %s dut%0d: %0d expected events never seen, first due cycle %0d",
                     kname(qi % 5), qi / 5, eq[qi].size(), eq[qi][0].cyc);
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
